// File: rtl/free_list_pkg.sv
// Shared types and sizes for the rename-stage physical register free list.
// Tags [NUM_GEN_REG, NUM_GEN_REG+FL_SIZE) are the ones that start out free.
package free_list_pkg;

  localparam int FL_SIZE     = 32;
  localparam int NUM_GEN_REG = 32;
  localparam int PHYS_W      = $clog2(NUM_GEN_REG + FL_SIZE);
  localparam int IDX_W       = $clog2(FL_SIZE);
  localparam int TAIL_W      = IDX_W + 1;

  typedef logic [PHYS_W-1:0]      PHYS_REG;
  typedef logic [TAIL_W-1:0]      FL_TAIL;
  typedef PHYS_REG [FL_SIZE-1:0]  fl_array_t;

  localparam FL_TAIL FL_TAIL_FULL = FL_TAIL'(FL_SIZE);

  function automatic fl_array_t fl_reset_array();
    fl_array_t a;
    for (int i = 0; i < FL_SIZE; i++) begin
      a[i] = PHYS_REG'(NUM_GEN_REG + i);
    end
    return a;
  endfunction

endpackage

// File: rtl/free_list_checker.sv
// Protocol checks for the free list: overflow on retire and restore room.
module free_list_checker
  import free_list_pkg::*;
(
  input logic   clock,
  input logic   reset,
  input logic   dispatch_en,
  input logic   retire_en,
  input logic   restore_en,
  input logic   full,
  input FL_TAIL tail,
  input FL_TAIL alloc_since,
  input FL_TAIL tail_restore
);

  // Sample legality conditions at each active edge outside reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      retire_full_a: assert (!(retire_en && !restore_en && full && !dispatch_en));
      restore_room_a: assert (!restore_en ||
        ((TAIL_W+1)'(tail) + (TAIL_W+1)'(alloc_since) <= (TAIL_W+1)'(FL_SIZE)));
      restore_snap_a: assert (!restore_en || (alloc_since <= tail_restore));
    end
  end

endmodule

// File: rtl/free_list_merge.sv
// Combinational restore merge: the first k snapshot entries (tags allocated
// since the checkpoint) are placed ahead of the live list contents.
module free_list_merge
  import free_list_pkg::*;
(
  input  fl_array_t snapshot,
  input  FL_TAIL    k,
  input  fl_array_t current,
  input  FL_TAIL    tail,
  output fl_array_t merged,
  output FL_TAIL    merged_tail
);

  logic [IDX_W-1:0] src_s;

  // Entry i comes from the snapshot below k, otherwise from live entry i-k.
  always_comb begin
    merged = current;
    src_s  = '0;
    for (int i = 0; i < FL_SIZE; i++) begin
      if (FL_TAIL'(i) < k) begin
        merged[i] = snapshot[i];
      end else begin
        src_s     = IDX_W'(i) - k[IDX_W-1:0];
        merged[i] = current[src_s];
      end
    end
    merged_tail = tail + k;
  end

endmodule

// File: rtl/free_list.sv
// Shift-array physical register free list: head is entry 0, tail equals count.
// Exports next-state array/tail for checkpoint capture and restores on mispredict.
module free_list
  import free_list_pkg::*;
(
  input  logic      clock,
  input  logic      reset,
  input  logic      dispatch_en,
  input  logic      retire_en,
  input  PHYS_REG   retire_T_old,
  input  logic      checkpoint_en,
  input  logic      restore_en,
  input  fl_array_t free_list_restore,
  input  FL_TAIL    tail_restore,
  output PHYS_REG   T_new,
  output logic      empty,
  output logic      full,
  output fl_array_t free_list_out,
  output FL_TAIL    tail_out
);

  fl_array_t list_q, list_d, merged_s;
  FL_TAIL    tail_q, tail_d, alloc_q, alloc_d, merged_tail_s, deq_tail_s;
  logic      deq_s, enq_s;

  free_list_merge u_merge (
    .snapshot    (free_list_restore),
    .k           (alloc_q),
    .current     (list_q),
    .tail        (tail_q),
    .merged      (merged_s),
    .merged_tail (merged_tail_s)
  );

  // Next state: restore takes priority over dequeue/enqueue.
  always_comb begin
    list_d     = list_q;
    tail_d     = tail_q;
    alloc_d    = alloc_q;
    deq_s      = 1'b0;
    enq_s      = 1'b0;
    deq_tail_s = tail_q;
    if (restore_en) begin
      list_d = merged_s;
      enq_s  = retire_en && (merged_tail_s < FL_TAIL_FULL);
      if (enq_s) begin
        list_d[merged_tail_s[IDX_W-1:0]] = retire_T_old;
        tail_d = merged_tail_s + FL_TAIL'(1);
      end else begin
        tail_d = merged_tail_s;
      end
      alloc_d = '0;
    end else begin
      deq_s = dispatch_en && (tail_q != '0);
      if (deq_s) begin
        for (int i = 0; i < FL_SIZE - 1; i++) begin
          list_d[i] = list_q[i+1];
        end
        deq_tail_s = tail_q - FL_TAIL'(1);
      end else begin
        deq_tail_s = tail_q;
      end
      // The freed tag lands at the post-dequeue tail.
      enq_s = retire_en && (deq_tail_s < FL_TAIL_FULL);
      if (enq_s) begin
        list_d[deq_tail_s[IDX_W-1:0]] = retire_T_old;
        tail_d = deq_tail_s + FL_TAIL'(1);
      end else begin
        tail_d = deq_tail_s;
      end
      if (checkpoint_en) begin
        alloc_d = '0;
      end else if (deq_s && (alloc_q != FL_TAIL_FULL)) begin
        alloc_d = alloc_q + FL_TAIL'(1);
      end else begin
        alloc_d = alloc_q;
      end
    end
  end

  // State registers with asynchronous reset to the initial free tags.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      list_q  <= fl_reset_array();
      tail_q  <= FL_TAIL_FULL;
      alloc_q <= '0;
    end else begin
      list_q  <= list_d;
      tail_q  <= tail_d;
      alloc_q <= alloc_d;
    end
  end

  assign T_new         = list_q[0];
  assign empty         = (tail_q == '0);
  assign full          = (tail_q == FL_TAIL_FULL);
  assign free_list_out = list_d;
  assign tail_out      = tail_d;

  free_list_checker u_checker (
    .clock        (clock),
    .reset        (reset),
    .dispatch_en  (dispatch_en),
    .retire_en    (retire_en),
    .restore_en   (restore_en),
    .full         (full),
    .tail         (tail_q),
    .alloc_since  (alloc_q),
    .tail_restore (tail_restore)
  );

endmodule

// File: tb/tb_free_list.sv
// Bench for free_list: vector table plus hand sequences, post-edge state
// expectations flow through a scoreboard queue.
module tb_free_list;
  import free_list_pkg::*;

  logic      clock = 1'b0;
  logic      reset = 1'b1;
  logic      dispatch_en = 1'b0;
  logic      retire_en = 1'b0;
  PHYS_REG   retire_T_old = '0;
  logic      checkpoint_en = 1'b0;
  logic      restore_en = 1'b0;
  fl_array_t free_list_restore;
  FL_TAIL    tail_restore;
  PHYS_REG   T_new;
  logic      empty, full;
  fl_array_t free_list_out;
  FL_TAIL    tail_out;

  fl_array_t snap = fl_reset_array();
  FL_TAIL    snap_tail = FL_TAIL_FULL;
  assign free_list_restore = snap;
  assign tail_restore      = snap_tail;

  int n_total = 0;
  int n_bad   = 0;

  typedef struct {
    string name;
    int    tail;
    int    tnew;
    bit    empty;
    bit    full;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    bit d;
    bit r;
    int t_old;
    bit c;
    bit x;
    int tail;
    int tnew;
  } vec_t;
  vec_t vecs [10];

  free_list dut (
    .clock             (clock),
    .reset             (reset),
    .dispatch_en       (dispatch_en),
    .retire_en         (retire_en),
    .retire_T_old      (retire_T_old),
    .checkpoint_en     (checkpoint_en),
    .restore_en        (restore_en),
    .free_list_restore (free_list_restore),
    .tail_restore      (tail_restore),
    .T_new             (T_new),
    .empty             (empty),
    .full              (full),
    .free_list_out     (free_list_out),
    .tail_out          (tail_out)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input bit d, input bit r, input int t_old, input bit c, input bit x);
    dispatch_en   = d;
    retire_en     = r;
    retire_T_old  = PHYS_REG'(t_old);
    checkpoint_en = c;
    restore_en    = x;
  endtask

  task automatic expect_post(input string nm, input int tail, input int tnew);
    exp_t e;
    e.name  = nm;
    e.tail  = tail;
    e.tnew  = tnew;
    e.empty = (tail == 0);
    e.full  = (tail == FL_SIZE);
    sb.push_back(e);
  endtask

  // One clock: emulate checkpoint capture, clock the edge, then score the new state.
  task automatic tick();
    exp_t e;
    #1;
    if (checkpoint_en && !restore_en) begin
      snap      = free_list_out;
      snap_tail = tail_out;
    end
    @(posedge clock);
    #1;
    drive(1'b0, 1'b0, 0, 1'b0, 1'b0);
    #1;
    if (sb.size() == 0) begin
      n_total++;
      n_bad++;
      $display("FAIL scoreboard: got no expectation, expected one per cycle");
    end else begin
      e = sb.pop_front();
      chk({e.name, "_tail"}, int'(tail_out), e.tail);
      chk({e.name, "_empty"}, int'(empty), int'(e.empty));
      chk({e.name, "_full"}, int'(full), int'(e.full));
      if (!e.empty) chk({e.name, "_tnew"}, int'(T_new), e.tnew);
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #1;
    reset = 1'b0;
    @(posedge clock);
    #2;
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b0, 0,  1'b0, 1'b0, 31, 33};
    vecs[1] = '{1'b1, 1'b0, 0,  1'b0, 1'b0, 30, 34};
    vecs[2] = '{1'b1, 1'b0, 0,  1'b0, 1'b0, 29, 35};
    vecs[3] = '{1'b1, 1'b1, 7,  1'b0, 1'b0, 29, 36};
    vecs[4] = '{1'b0, 1'b0, 0,  1'b1, 1'b0, 29, 36};
    vecs[5] = '{1'b1, 1'b0, 0,  1'b0, 1'b0, 28, 37};
    vecs[6] = '{1'b1, 1'b0, 0,  1'b0, 1'b0, 27, 38};
    vecs[7] = '{1'b0, 1'b0, 0,  1'b0, 1'b1, 29, 36};
    vecs[8] = '{1'b0, 1'b0, 0,  1'b0, 1'b1, 29, 36};
    vecs[9] = '{1'b1, 1'b1, 12, 1'b0, 1'b1, 30, 36};

    #7;
    reset = 1'b0;
    chk("rst_tnew", int'(T_new), 32);
    chk("rst_full", int'(full), 1);
    chk("rst_empty", int'(empty), 0);
    chk("rst_tail", int'(tail_out), 32);

    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].d, vecs[i].r, vecs[i].t_old, vecs[i].c, vecs[i].x);
      expect_post($sformatf("vec%0d", i), vecs[i].tail, vecs[i].tnew);
      tick();
    end
    chk("vec_entry29", int'(free_list_out[29]), 12);

    // Drain completely, dispatch while empty, then refill with one tag.
    pulse_reset();
    for (int i = 0; i < FL_SIZE; i++) begin
      drive(1'b1, 1'b0, 0, 1'b0, 1'b0);
      chk($sformatf("drain%0d_pre", i), int'(T_new), 32 + i);
      expect_post($sformatf("drain%0d", i), 31 - i, 33 + i);
      tick();
    end
    drive(1'b1, 1'b0, 0, 1'b0, 1'b0);
    expect_post("deq_empty", 0, 0);
    tick();
    drive(1'b0, 1'b1, 5, 1'b0, 1'b0);
    expect_post("refill5", 1, 5);
    tick();

    // Grow to tail 10, then dispatch and retire together.
    for (int i = 0; i < 9; i++) begin
      drive(1'b0, 1'b1, 10 + i, 1'b0, 1'b0);
      expect_post($sformatf("fill%0d", i), 2 + i, 5);
      tick();
    end
    drive(1'b1, 1'b1, 7, 1'b0, 1'b0);
    expect_post("deq_enq", 10, 10);
    tick();
    chk("deq_enq_e9", int'(free_list_out[9]), 7);
    chk("deq_enq_e8", int'(free_list_out[8]), 18);

    // Checkpoint after two allocations, three more, retire tag 3, restore.
    pulse_reset();
    drive(1'b1, 1'b0, 0, 1'b0, 1'b0); expect_post("c_d0", 31, 33); tick();
    drive(1'b1, 1'b0, 0, 1'b0, 1'b0); expect_post("c_d1", 30, 34); tick();
    drive(1'b0, 1'b0, 0, 1'b1, 1'b0); expect_post("c_ckpt", 30, 34); tick();
    drive(1'b1, 1'b0, 0, 1'b0, 1'b0); expect_post("c_d2", 29, 35); tick();
    drive(1'b1, 1'b0, 0, 1'b0, 1'b0); expect_post("c_d3", 28, 36); tick();
    drive(1'b1, 1'b0, 0, 1'b0, 1'b0); expect_post("c_d4", 27, 37); tick();
    drive(1'b0, 1'b1, 3, 1'b0, 1'b0); expect_post("c_ret3", 28, 37); tick();
    drive(1'b0, 1'b0, 0, 1'b0, 1'b1); expect_post("c_restore", 31, 34); tick();
    chk("c_e2", int'(free_list_out[2]), 36);
    chk("c_e3", int'(free_list_out[3]), 37);
    chk("c_e29", int'(free_list_out[29]), 63);
    chk("c_e30", int'(free_list_out[30]), 3);

    // Restore with concurrent retire, dispatch and checkpoint.
    drive(1'b0, 1'b0, 0, 1'b1, 1'b0); expect_post("d_ckpt", 31, 34); tick();
    drive(1'b1, 1'b0, 0, 1'b0, 1'b0); expect_post("d_d0", 30, 35); tick();
    drive(1'b1, 1'b0, 0, 1'b0, 1'b0); expect_post("d_d1", 29, 36); tick();
    drive(1'b1, 1'b1, 9, 1'b1, 1'b1); expect_post("d_restore", 32, 34); tick();
    chk("d_e31", int'(free_list_out[31]), 9);
    chk("d_e30", int'(free_list_out[30]), 3);
    chk("d_e1", int'(free_list_out[1]), 35);
    drive(1'b0, 1'b0, 0, 1'b0, 1'b1); expect_post("d_restore0", 32, 34); tick();

    // Asynchronous reset between edges with allocations outstanding.
    drive(1'b0, 1'b0, 0, 1'b1, 1'b0); expect_post("e_ckpt", 32, 34); tick();
    drive(1'b1, 1'b0, 0, 1'b0, 1'b0); expect_post("e_d0", 31, 35); tick();
    drive(1'b1, 1'b0, 0, 1'b0, 1'b0); expect_post("e_d1", 30, 36); tick();
    #1;
    reset = 1'b1;
    #1;
    chk("arst_tnew", int'(T_new), 32);
    chk("arst_tail", int'(tail_out), 32);
    chk("arst_full", int'(full), 1);
    chk("arst_empty", int'(empty), 0);
    reset = 1'b0;
    @(posedge clock);
    #2;
    drive(1'b0, 1'b0, 0, 1'b0, 1'b1); expect_post("e_restore0", 32, 32); tick();
    chk("e_e31", int'(free_list_out[31]), 63);

    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
